// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with a per-register pending (scoreboard) bit,
// write-to-read bypass and a sequential clear sweep that zeroes one entry per cycle.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         waddr0,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         waddr1,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic [NUM_RD-1:0]         re,
    input  logic [NUM_RD*ADDR_W-1:0]  raddr,
    output logic [NUM_RD*DATA_W-1:0]  rdata,
    output logic [NUM_RD-1:0]         busy,
    input  logic                      iss_en,
    input  logic [ADDR_W-1:0]         iss_addr,
    input  logic                      clr_req,
    output logic                      clr_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]   regs_reg [DEPTH];
    logic [DEPTH-1:0]    pending_reg;

    logic wr0_ok, wr1_ok, iss_ok;
    assign wr0_ok = we0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign wr1_ok = we1 && !(ZERO_REG != 0 && waddr1 == '0);
    assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);

    assign clr_busy = (state_reg == SWEEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            pending_reg <= '0;
            cnt_reg     <= '0;
            state_reg   <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Port 1 assigned last so it wins on an address collision; the
                    // issue mark is applied after the write clears so a new producer wins.
                    if (wr0_ok) begin
                        regs_reg[waddr0]    <= wdata0;
                        pending_reg[waddr0] <= 1'b0;
                    end
                    if (wr1_ok) begin
                        regs_reg[waddr1]    <= wdata1;
                        pending_reg[waddr1] <= 1'b0;
                    end
                    if (iss_ok) begin
                        pending_reg[iss_addr] <= 1'b1;
                    end
                    if (clr_req) begin
                        state_reg <= SWEEP;
                        cnt_reg   <= '0;
                    end
                end
                SWEEP: begin
                    regs_reg[cnt_reg]    <= '0;
                    pending_reg[cnt_reg] <= 1'b0;
                    if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              zero_hit, hit0, hit1;

            assign addr     = raddr[gi*ADDR_W +: ADDR_W];
            assign zero_hit = (ZERO_REG != 0) && (addr == '0);
            // Bypass is suppressed while sweeping because writes are not taken then.
            assign hit1     = we1 && (waddr1 == addr) && !clr_busy;
            assign hit0     = we0 && (waddr0 == addr) && !clr_busy;

            always_comb begin
                rdata[gi*DATA_W +: DATA_W] = '0;
                busy[gi]                   = 1'b0;
                if (rst) begin
                    if (re[gi] && !zero_hit) begin
                        if (hit1)      rdata[gi*DATA_W +: DATA_W] = wdata1;
                        else if (hit0) rdata[gi*DATA_W +: DATA_W] = wdata0;
                        else           rdata[gi*DATA_W +: DATA_W] = regs_reg[addr];
                    end
                    busy[gi] = clr_busy |
                               (re[gi] & pending_reg[addr] & ~hit0 & ~hit1 & ~zero_hit);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboarded bench for regfile_sb: read expectations are queued as stimulus is
// driven and compared against rdata/busy just before the next rising edge.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              we0, we1, iss_en, clr_req, clr_busy;
    logic [AW-1:0]     waddr0, waddr1, iss_addr;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NR-1:0]     re, busy;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .busy(busy),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] data;
        logic        bsy;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mdl [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        we0 = 0; we1 = 0; iss_en = 0; clr_req = 0; re = '0; raddr = '0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
    endtask

    task automatic wr0(input int a, input logic [31:0] d);
        we0 = 1; waddr0 = AW'(a); wdata0 = d;
    endtask

    task automatic wr1(input int a, input logic [31:0] d);
        we1 = 1; waddr1 = AW'(a); wdata1 = d;
    endtask

    task automatic iss(input int a);
        iss_en = 1; iss_addr = AW'(a);
    endtask

    // Drive a read and queue what the DUT must present on that port this cycle.
    task automatic rd(input int port, input int a, input logic [31:0] d, input logic b,
                      input string tag);
        exp_t e;
        re[port] = 1'b1;
        raddr[port*AW +: AW] = AW'(a);
        e.tag = tag; e.port = port; e.data = d; e.bsy = b;
        sb_q.push_back(e);
    endtask

    // Settle, drain the scoreboard, then cross one rising edge.
    task automatic step();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, "_data"}, rdata[e.port*DW +: DW], e.data);
            chk({e.tag, "_busy"}, {31'b0, busy[e.port]}, {31'b0, e.bsy});
            $display("txn %0t %s port%0d data=%h busy=%b", $time, e.tag, e.port,
                     rdata[e.port*DW +: DW], busy[e.port]);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic fill();
        for (int i = 1; i < DEPTH; i += 2) begin
            mdl[i] = 32'h0101_0101 * i ^ 32'hA500_0000;
            wr0(i, mdl[i]);
            if (i + 1 < DEPTH) begin
                mdl[i+1] = 32'h0101_0101 * (i + 1) ^ 32'hA500_0000;
                wr1(i + 1, mdl[i+1]);
            end
            step();
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < DEPTH; i += 2) begin
            rd(0, i, 32'h0, 1'b0, tag);
            rd(1, i + 1, 32'h0, 1'b0, tag);
            step();
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        #1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        // Held in reset: a bypassable write must not leak to rdata.
        wr1(3, 32'h55);
        rd(0, 3, 32'h0, 1'b0, "rst_rd0");
        rd(1, 3, 32'h0, 1'b0, "rst_rd1");
        #2;
        chk("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
        step();
        rst = 1'b1;
        step();

        // 1: write then read on the other port.
        wr0(5, 32'hDEAD_BEEF);
        step();
        rd(1, 5, 32'hDEAD_BEEF, 1'b0, "t1_r5");
        step();

        // 2: dual write to same address, port 1 wins; bypass then stored.
        wr0(7, 32'h11);
        wr1(7, 32'h22);
        rd(0, 7, 32'h22, 1'b0, "t2_byp");
        step();
        rd(0, 7, 32'h22, 1'b0, "t2_reg0");
        rd(1, 7, 32'h22, 1'b0, "t2_reg1");
        step();

        // 3: issue -> busy next cycle, cleared by a same-cycle write hit.
        iss(9);
        rd(0, 9, 32'h0, 1'b0, "t3_sameiss");
        step();
        rd(0, 9, 32'h0, 1'b1, "t3_pend");
        rd(1, 5, 32'hDEAD_BEEF, 1'b0, "t3_other");
        step();
        wr0(9, 32'h33);
        rd(1, 9, 32'h33, 1'b0, "t3_byp");
        step();
        rd(0, 9, 32'h33, 1'b0, "t3_after");
        step();

        // 4: issue and write together leave the register pending.
        iss(4);
        wr1(4, 32'h44);
        step();
        rd(0, 4, 32'h44, 1'b1, "t4_r4");
        step();

        // 5: register 0 is hard-wired; disabled port reads 0.
        wr0(0, 32'hFF);
        iss(0);
        rd(0, 0, 32'h0, 1'b0, "t5_same");
        step();
        rd(0, 0, 32'h0, 1'b0, "t5_r0");
        rd(1, 5, 32'h0, 1'b0, "t5_re_off");
        re[1] = 1'b0;
        step();

        // 6a: full sweep with writes/issues ignored while running.
        fill();
        for (int i = 1; i < DEPTH; i += 2) begin
            rd(0, i, mdl[i], 1'b0, "t6_fill");
            rd(1, (i + 1) % DEPTH, (i + 1 < DEPTH) ? mdl[i+1] : 32'h0, 1'b0, "t6_fill");
            step();
        end
        iss(12);
        step();
        clr_req = 1'b1;
        step();
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 0) begin
                wr1(31, 32'hBAD0_0BAD);
                rd(0, 31, mdl[31], 1'b1, "t6_sweep_nobyp");
            end
            if (k == 20) wr0(1, 32'hBAD);
            if (k == 25) iss(2);
            if (k == 5) begin
                re = '0;
                #2;
                chk("t6_busy_forced", {30'b0, busy}, 32'h3);
            end
            #0;
            chk("t6_clr_busy_hi", {31'b0, clr_busy}, 32'h1);
            step();
        end
        #1;
        chk("t6_clr_busy_done", {31'b0, clr_busy}, 32'h0);
        rd(0, 12, 32'h0, 1'b0, "t6_pend_clr");
        rd(1, 2, 32'h0, 1'b0, "t6_iss_ignored");
        step();
        read_all_zero("t6_zero");

        // 6b: reset pulsed at sweep cycle 10.
        fill();
        clr_req = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            chk("t6b_clr_busy_hi", {31'b0, clr_busy}, 32'h1);
            step();
        end
        rst = 1'b0;
        rd(0, 20, 32'h0, 1'b0, "t6b_in_rst");
        #1;
        chk("t6b_clr_busy_rst", {31'b0, clr_busy}, 32'h0);
        step();
        rst = 1'b1;
        #1;
        chk("t6b_clr_busy_after", {31'b0, clr_busy}, 32'h0);
        read_all_zero("t6b_zero");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
